mem_arbiter: RTL and testbench

Sequencing arbiter that shares one single-port, fixed-latency memory between the pipeline's instruction-fetch port and data-memory port. It grants one access at a time and drives the shared memory port. It returns read data with a one-cycle completion pulse and produces per-port stall signals that the pipeline registers use to hold IF/ID and EX/MEM.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency memory between the
// instruction-fetch (if) and data-memory (dm) requesters. One access at a
// time: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE -> IDLE.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// DM has fixed priority over IF.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    state_t            state_q;
    logic              owner_dm_q;   // 1 = current access belongs to DM
    logic              we_q;         // latched write flag of current access
    logic [3:0]        cnt_q;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_done_q, dm_done_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              win_dm;       // arbitration result for this IDLE cycle

`ifdef MEM_ARB_RR_EN
    logic ptr_q;                     // last granted port, 1 = DM

    // On a conflict the port that was not granted last time wins
    assign win_dm = dm_req & (~if_req | ~ptr_q);

    // Remember the last granted port; updated on every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= 1'b0;
        else if (state_q == S_IDLE && (if_req | dm_req))
            ptr_q <= win_dm;
    end
`else
    // Fixed priority: DM always beats IF
    assign win_dm = dm_req;
`endif

    // Sequencing FSM with registered memory strobes, done pulses and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_dm_q  <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (if_req | dm_req) begin
                        // Latch the winner so the memory port is driven in ACCESS
                        owner_dm_q <= win_dm;
                        we_q       <= win_dm & dm_we;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= win_dm & dm_we;
                        mem_addr_q <= win_dm ? dm_addr : if_addr;
                        if (win_dm)
                            mem_wdata_q <= dm_wdata;
                        state_q    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    cnt_q    <= LAT4;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        // Memory data is valid in this last WAIT cycle
                        if (!we_q) begin
                            if (owner_dm_q)
                                dm_rdata_q <= mem_rdata;
                            else
                                if_rdata_q <= mem_rdata;
                        end
                        if_done_q <= ~owner_dm_q;
                        dm_done_q <= owner_dm_q;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign stall_if  = if_req & ~if_done_q;
    assign stall_dm  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: randomized requesters, a cycle-level reference
// model that predicts grants from the arbitration rules and fixed latency,
// and a scoreboard monitor that compares every DUT output at each negedge.
module tb_mem_arbiter;
    localparam int LAT = 2;

    typedef struct {
        int          c;
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic        if_done, dm_done, mem_en, mem_we, stall_if, stall_dm, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // scoreboard / model state
    ev_t men_q[$];
    ev_t done_q[$];
    ev_t m_e;
    int  free_at = 0;
    int  grant_c = -10;
    bit  rr_last_dm = 1'b0;
    bit  sb_en = 1'b0;
    bit  log_en = 1'b0;
    bit  own_log[$];
    bit  xd_if, xd_dm, xm, pdm;
    logic [31:0] exp_if_rd = '0, exp_dm_rd = '0;
    int          rd_c[$];
    logic [31:0] rd_a[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_dm(stall_dm), .busy(busy)
    );

    // Two extra instances for the latency extremes (MEM_LAT = 1 and 15)
    logic [1:0]  x_req = 2'b00;
    logic [1:0]  x_ifdone, x_dmdone, x_men, x_mwe, x_sif, x_sdm, x_busy;
    logic [31:0] x_ifrd[2], x_dmrd[2], x_maddr[2], x_mwd[2], x_mrd[2];

    for (genvar g = 0; g < 2; g++) begin : g_lat
        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 15)) u (
            .clk(clk), .rst(rst),
            .if_req(x_req[g]), .if_addr(32'h100), .if_done(x_ifdone[g]), .if_rdata(x_ifrd[g]),
            .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
            .dm_done(x_dmdone[g]), .dm_rdata(x_dmrd[g]),
            .mem_en(x_men[g]), .mem_we(x_mwe[g]), .mem_addr(x_maddr[g]), .mem_wdata(x_mwd[g]),
            .mem_rdata(x_mrd[g]),
            .stall_if(x_sif[g]), .stall_dm(x_sdm[g]), .busy(x_busy[g])
        );
    end

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic fail(input string n, input logic [63:0] a, input logic [63:0] x);
        ntests++;
        nfail++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, x, cyc);
    endtask

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        if (a !== x) fail(n, a, x);
        else ntests++;
    endtask

    // Memory models: main memory returns hash(addr) only in the valid cycle,
    // the latency instances return a cycle-stamped word every cycle
    always @(negedge clk) begin
        if (mem_en && !mem_we) begin
            rd_c.push_back(cyc + LAT);
            rd_a.push_back(mem_addr);
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rdata = $urandom();
        if (rd_c.size() > 0 && rd_c[0] == cyc) begin
            mem_rdata = hash(rd_a[0]);
            void'(rd_c.pop_front());
            void'(rd_a.pop_front());
        end
        for (int g = 0; g < 2; g++) x_mrd[g] = {16'hC0DE, 16'(cyc)};
    end

    // Monitor (compare against predictions) followed by the reference model
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            while (done_q.size() > 0 && done_q[0].c < cyc) begin
                fail("done_missing", 0, 1);
                void'(done_q.pop_front());
            end
            while (men_q.size() > 0 && men_q[0].c < cyc) begin
                fail("mem_en_missing", 0, 1);
                void'(men_q.pop_front());
            end
            xd_if = 1'b0;
            xd_dm = 1'b0;
            if (done_q.size() > 0 && done_q[0].c == cyc) begin
                if (done_q[0].dm) xd_dm = 1'b1;
                else              xd_if = 1'b1;
            end
            chk("if_done", if_done, xd_if);
            chk("dm_done", dm_done, xd_dm);
            if (log_en && (if_done || dm_done)) own_log.push_back(dm_done);
            if (xd_if || xd_dm) begin
                m_e = done_q.pop_front();
                if (!m_e.we) begin
                    if (m_e.dm) exp_dm_rd = m_e.rdata;
                    else        exp_if_rd = m_e.rdata;
                end
            end
            chk("if_rdata", if_rdata, exp_if_rd);
            chk("dm_rdata", dm_rdata, exp_dm_rd);
            chk("stall_if", stall_if, if_req && !xd_if);
            chk("stall_dm", stall_dm, dm_req && !xd_dm);
            chk("busy", busy, (cyc > grant_c) && (cyc < free_at));
            xm = (men_q.size() > 0 && men_q[0].c == cyc);
            chk("mem_en", mem_en, xm);
            if (xm) begin
                m_e = men_q.pop_front();
                chk("mem_addr", mem_addr, m_e.addr);
                chk("mem_we", mem_we, m_e.we);
                if (m_e.we) chk("mem_wdata", mem_wdata, m_e.wdata);
            end else begin
                chk("mem_we_idle", mem_we, 1'b0);
            end

            // Reference: a free arbiter grants one requester, fixed latency follows
            if (cyc >= free_at && (if_req || dm_req)) begin
`ifdef MEM_ARB_RR_EN
                pdm = dm_req && (!if_req || !rr_last_dm);
                rr_last_dm = pdm;
`else
                pdm = dm_req;
`endif
                m_e.dm    = pdm;
                m_e.we    = pdm && dm_we;
                m_e.addr  = pdm ? dm_addr : if_addr;
                m_e.wdata = dm_wdata;
                m_e.rdata = hash(m_e.addr);
                m_e.c     = cyc + 1;
                men_q.push_back(m_e);
                m_e.c     = cyc + 2 + LAT;
                done_q.push_back(m_e);
                grant_c   = cyc;
                free_at   = cyc + 3 + LAT;
            end
        end
    end

    task automatic drive_if(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if_addr = 32'($urandom_range(0, 255)) << 2;
            if_req  = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!if_done && t < 200);
            if (!if_done) fail("if_timeout", 0, 1);
            @(posedge clk); #1;
            if_req = 1'b0;
        end
    endtask

    task automatic drive_dm(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            dm_addr  = 32'($urandom_range(0, 255)) << 2;
            dm_we    = 1'($urandom_range(0, 1));
            dm_wdata = $urandom();
            dm_req   = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!dm_done && t < 200);
            if (!dm_done) fail("dm_timeout", 0, 1);
            @(posedge clk); #1;
            dm_req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, dc0, dc1, nd;
        bit exp_own[4];

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        sb_en = 1'b1;

        // Latency extremes on the side instances
        @(posedge clk); #1;
        base = cyc;
        x_req = 2'b11;
        dc0 = -1;
        dc1 = -1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (x_ifdone[0] && dc0 < 0) begin dc0 = cyc; x_req[0] = 1'b0; end
            if (x_ifdone[1] && dc1 < 0) begin dc1 = cyc; x_req[1] = 1'b0; end
        end
        chk("lat1_done_cycle", dc0, base + 3);
        chk("lat15_done_cycle", dc1, base + 17);
        chk("lat1_rdata", x_ifrd[0], {16'hC0DE, 16'(base + 2)});
        chk("lat15_rdata", x_ifrd[1], {16'hC0DE, 16'(base + 16)});

        // Both requests held for four accesses: owner order
        @(posedge clk); #1;
        if_addr = 32'h20; dm_addr = 32'h40; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        log_en = 1'b1;
        for (int t = 0; t < 100 && own_log.size() < 4; t++) @(negedge clk);
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;
        log_en = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        chk("own_count", own_log.size(), 4);
        for (int i = 0; i < 4 && i < own_log.size(); i++) chk("owner_seq", own_log[i], exp_own[i]);

        // Randomized traffic from both ports
        repeat (4) begin @(posedge clk); #1; end
        fork
            drive_if(40);
            drive_dm(40);
        join
        repeat (10) begin @(posedge clk); #1; end
        chk("men_q_drained", men_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        // Reset in the middle of a read
        sb_en = 1'b0;
        if_addr = 32'h44; if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; if_req = 1'b0;
        #1;
        chk("mrst_mem_en", mem_en, 0);
        chk("mrst_mem_we", mem_we, 0);
        chk("mrst_mem_addr", mem_addr, 0);
        chk("mrst_mem_wdata", mem_wdata, 0);
        chk("mrst_if_done", if_done, 0);
        chk("mrst_dm_done", dm_done, 0);
        chk("mrst_if_rdata", if_rdata, 0);
        chk("mrst_dm_rdata", dm_rdata, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_stall_if", stall_if, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        men_q.delete(); done_q.delete();
        free_at = 0; grant_c = -10; rr_last_dm = 1'b0;
        exp_if_rd = '0; exp_dm_rd = '0;
        sb_en = 1'b1;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_done || dm_done || busy) nd++;
        end
        chk("post_rst_quiet", nd, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
